alignment_lock: RTL and testbench
=================================

ALIGNMENT_LOCK -- requirements
Module: alignment_lock

Interface
REQ-001 Parameter AM_INTERVAL, default 16384, meaning: valid blocks from one marker to the next, marker included; legal values are a power of 2 and at least 8.
REQ-002 Parameter INVALID_LIMIT, default 4, meaning: consecutive bad markers while locked that cause loss of lock.
REQ-003 Port clk, input, 1 bit: sole clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port block_in, input, 66 bits: received 66b block for one PCS lane; bits [1:0] are the sync header.
REQ-006 Port block_valid, input, 1 bit: block_in is a new block this cycle.
REQ-007 Port block_lock, input, 1 bit: block synchronisation lock from the upstream block-sync stage.
REQ-008 Port block_out, output, 66 bits: registered copy of block_in.
REQ-009 Port block_out_valid, output, 1 bit: block_out holds a data block; low for removed markers.
REQ-010 Port am_lock, output, 1 bit: alignment marker lock achieved.
REQ-011 Port lane_id, output, 2 bits: PCS lane number decoded from the locked marker.
REQ-012 Port bip_error, output, 1 bit: one-cycle pulse on a BIP3 mismatch.
REQ-013 Port bip_err_count, output, 16 bits: saturating count of BIP errors.

Function
REQ-014 Marker match SHALL require all of the following; BIP bytes are excluded from matching:
- bits [1:0] = 2'b01;
- bits [25:2] = lane pattern P;
- bits [57:34] = ~P.
REQ-015 Lane patterns for bits [25:2] SHALL be:
- lane 0: 24'h477690;
- lane 1: 24'hE6C4F0;
- lane 2: 24'h9B65C5;
- lane 3: 24'h3D79A2.
REQ-016 Only cycles with block_valid=1 SHALL advance the counter, the FSM or the BIP accumulator.
REQ-017 BIP accumulator bit i SHALL be the XOR of block bits 2+i+8k, k=0..7.
- Bit 3 additionally XORs bit 0; bit 4 additionally XORs bit 1.
REQ-018 At each consumed marker the accumulator SHALL reload with that marker block's own 66-bit parity (BIP fields included); otherwise it XORs in each valid block.
REQ-019 FSM states SHALL be FIND_1ST, COUNT_1 and LOCKED; reset value is FIND_1ST.
REQ-020 FIND_1ST: a matching block SHALL capture lane_id, clear the position counter and go to COUNT_1.
REQ-021 COUNT_1: at the AM_INTERVAL-th valid block after the first marker:
- matching marker with the same lane -> LOCKED, with am_lock=1 from the next cycle;
- otherwise -> FIND_1ST.
REQ-022 LOCKED, at each expected position:
- matching marker with the same lane -> invalid count cleared;
- otherwise -> invalid count incremented.
REQ-023 LOCKED: when the invalid count reaches INVALID_LIMIT, the FSM SHALL go to FIND_1ST, with am_lock=0 next cycle.
REQ-024 Markers at non-expected positions SHALL be treated as data, with no FSM effect.
REQ-025 The position counter SHALL be $clog2(AM_INTERVAL) bits and wrap naturally; the expected position is counter = AM_INTERVAL-1 before increment.
REQ-026 BIP3 check (LOCKED, expected position, matching lane only):
- compare received bits [33:26] with the accumulator value before reload;
- on mismatch, pulse bip_error for 1 cycle and increment bip_err_count, saturating at 16'hFFFF.
REQ-027 Received bits [65:58] SHALL NOT be checked.
REQ-028 The first marker after entering LOCKED is BIP-checked; the marker that caused entry into COUNT_1 is not.
REQ-029 Marker removal: block_out_valid=0 for blocks consumed as markers, namely:
- the FIND_1ST match;
- every expected-position block in COUNT_1 or LOCKED.
REQ-030 All other blocks SHALL appear on block_out with block_out_valid = block_valid, 1-cycle latency.
REQ-031 block_lock=0 SHALL force FIND_1ST next cycle:
- am_lock=0;
- invalid count and accumulator cleared;
- bip_err_count held.
REQ-032 block_lock and reset both SHALL override any same-cycle marker event.
REQ-033 A bad marker and a BIP error cannot coincide, because BIP is checked on matching markers only.

Reset
REQ-034 On reset=1 at a clock edge the following SHALL hold next cycle:
- block_out=0, block_out_valid=0;
- am_lock=0, lane_id=0;
- bip_error=0, bip_err_count=0;
- FSM in FIND_1ST, counter=0, invalid count=0, accumulator=0.
REQ-035 Reset asserted mid-lock SHALL drop am_lock on the next cycle and discard all state.

Verification (AM_INTERVAL=16, INVALID_LIMIT=4)
REQ-036 Lane 2 markers every 16 valid blocks with correct BIP:
- am_lock=1 the cycle after the 2nd marker, lane_id=2;
- bip_error never pulses;
- markers absent from block_out_valid.
REQ-037 Locked on lane 0, one data bit flipped between markers -> one bip_error pulse at the next marker, bip_err_count=1.
REQ-038 Locked, with markers corrupted at 4 consecutive expected positions -> am_lock stays 1 through the first 3, and falls the cycle after the 4th.
REQ-039 Lane 1 marker followed by a lane 3 marker 16 blocks later -> back to FIND_1ST, am_lock stays 0.
REQ-040 block_valid toggled randomly during lock -> positions track valid blocks only and lock is held.
REQ-041 Locked, then block_lock=0 for 1 cycle -> am_lock=0 next cycle; relock after two markers with bip_err_count unchanged.

Source files
------------

// File: rtl/alignment_lock.sv
// Alignment-marker lock for one 66b PCS lane: finds the lane marker, confirms it
// one interval later, tracks lock with a bad-marker budget, strips consumed markers
// from the output stream and checks BIP3 on every good marker while locked.
module alignment_lock #(
  parameter int AM_INTERVAL   = 16384,
  parameter int INVALID_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [65:0] block_in,
  input  logic        block_valid,
  input  logic        block_lock,
  output logic [65:0] block_out,
  output logic        block_out_valid,
  output logic        am_lock,
  output logic [1:0]  lane_id,
  output logic        bip_error,
  output logic [15:0] bip_err_count
);

  localparam int CW = $clog2(AM_INTERVAL);
  localparam int IW = $clog2(INVALID_LIMIT + 1);
  localparam logic [CW-1:0] LAST_POS = CW'(AM_INTERVAL - 1);
  localparam logic [IW-1:0] INV_MAX  = IW'(INVALID_LIMIT);

  typedef enum logic [1:0] {
    FIND_1ST = 2'd0,
    COUNT_1  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] pos, pos_nxt;
  logic [IW-1:0] inv_cnt, inv_nxt;
  logic [7:0]    acc, acc_nxt;
  logic [1:0]    lane_nxt;
  logic          match;
  logic [1:0]    match_lane;
  logic          consume;
  logic          bip_hit;

  function automatic logic [23:0] lane_pattern(input logic [1:0] l);
    case (l)
      2'd0:    return 24'h477690;
      2'd1:    return 24'hE6C4F0;
      2'd2:    return 24'h9B65C5;
      default: return 24'h3D79A2;
    endcase
  endfunction

  // Bit i folds block bits 2+i+8k; the sync header lands on bits 3 and 4.
  function automatic logic [7:0] block_parity(input logic [65:0] b);
    logic [7:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) begin
      p = p ^ b[2+8*k +: 8];
    end
    p[3] = p[3] ^ b[0];
    p[4] = p[4] ^ b[1];
    return p;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Marker detection against all four lane patterns; BIP bytes are ignored.
  always_comb begin
    match      = 1'b0;
    match_lane = 2'd0;
    for (int l = 0; l < 4; l++) begin
      if (block_in[1:0] == 2'b01 &&
          block_in[25:2] == lane_pattern(2'(l)) &&
          block_in[57:34] == ~lane_pattern(2'(l))) begin
        match      = 1'b1;
        match_lane = 2'(l);
      end
    end
  end

  // Next-state, position, invalid-count, BIP accumulator and marker-consume decisions.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    inv_nxt   = inv_cnt;
    acc_nxt   = acc;
    lane_nxt  = lane_id;
    consume   = 1'b0;
    bip_hit   = 1'b0;
    if (!block_lock) begin
      state_nxt = FIND_1ST;
      pos_nxt   = '0;
      inv_nxt   = '0;
      acc_nxt   = '0;
    end else if (block_valid) begin
      pos_nxt = pos + 1'b1;
      unique case (state)
        FIND_1ST: begin
          if (match) begin
            lane_nxt  = match_lane;
            pos_nxt   = '0;
            state_nxt = COUNT_1;
            consume   = 1'b1;
          end
        end
        COUNT_1: begin
          if (pos == LAST_POS) begin
            consume   = 1'b1;
            inv_nxt   = '0;
            state_nxt = (match && match_lane == lane_id) ? LOCKED : FIND_1ST;
          end
        end
        LOCKED: begin
          if (pos == LAST_POS) begin
            consume = 1'b1;
            if (match && match_lane == lane_id) begin
              inv_nxt = '0;
              bip_hit = (block_in[33:26] != acc);
            end else if (inv_cnt + 1'b1 == INV_MAX) begin
              inv_nxt   = '0;
              state_nxt = FIND_1ST;
            end else begin
              inv_nxt = inv_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = FIND_1ST;
      endcase
      // A consumed marker starts the next BIP interval with its own parity.
      acc_nxt = consume ? block_parity(block_in) : (acc ^ block_parity(block_in));
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FIND_1ST;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath, counters and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos             <= '0;
      inv_cnt         <= '0;
      acc             <= '0;
      lane_id         <= '0;
      block_out       <= '0;
      block_out_valid <= 1'b0;
      bip_error       <= 1'b0;
      bip_err_count   <= '0;
    end else begin
      pos             <= pos_nxt;
      inv_cnt         <= inv_nxt;
      acc             <= acc_nxt;
      lane_id         <= lane_nxt;
      block_out       <= block_in;
      block_out_valid <= block_valid & ~consume;
      bip_error       <= bip_hit;
      if (bip_hit) begin
        bip_err_count <= sat_inc(bip_err_count);
      end
    end
  end

  assign am_lock = (state == LOCKED);

endmodule

// File: tb/tb_alignment_lock.sv
// Randomised bench for alignment_lock with a marker-level reference model.
module tb_alignment_lock;

  localparam int AM  = 16;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [65:0] block_in = '0;
  logic        block_valid = 1'b0;
  logic        block_lock = 1'b0;
  logic [65:0] block_out;
  logic        block_out_valid;
  logic        am_lock;
  logic [1:0]  lane_id;
  logic        bip_error;
  logic [15:0] bip_err_count;

  int checks = 0;
  int errors = 0;

  // Reference model: blocks since the last consumed marker, plus lock bookkeeping.
  logic [65:0] seg[$];
  bit          m_lock, m_cand, e_ov, e_bip;
  int          m_pos, m_bad, m_cnt;
  logic [1:0]  m_lane;
  logic [65:0] e_out;

  alignment_lock #(.AM_INTERVAL(AM), .INVALID_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .block_in(block_in), .block_valid(block_valid),
    .block_lock(block_lock), .block_out(block_out), .block_out_valid(block_out_valid),
    .am_lock(am_lock), .lane_id(lane_id), .bip_error(bip_error), .bip_err_count(bip_err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] lane_pat(input logic [1:0] l);
    logic [23:0] t[4];
    t[0] = 24'h477690; t[1] = 24'hE6C4F0; t[2] = 24'h9B65C5; t[3] = 24'h3D79A2;
    return t[l];
  endfunction

  function automatic bit is_marker(input logic [65:0] b, output logic [1:0] l);
    l = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (b[1:0] == 2'b01 && b[25:2] == lane_pat(2'(i)) && b[57:34] == ~lane_pat(2'(i))) begin
        l = 2'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // BIP3 of the current interval, bit by bit from the parity definition.
  function automatic logic [7:0] seg_par();
    logic [7:0] p;
    p = '0;
    foreach (seg[n]) begin
      for (int j = 0; j < 66; j++) begin
        if (j >= 2) p[(j-2)%8] = p[(j-2)%8] ^ seg[n][j];
        else        p[j+3]     = p[j+3] ^ seg[n][j];
      end
    end
    return p;
  endfunction

  function automatic logic [65:0] rnd_data();
    logic [65:0] b;
    b = {$urandom, $urandom, $urandom};
    if (b[1:0] == 2'b01) b[57:34] = b[25:2];
    return b;
  endfunction

  // kind 0: good marker, 1: corrupted pattern, 2: wrong BIP3.
  function automatic logic [65:0] mk(input logic [1:0] l, input int kind);
    logic [65:0] b;
    b = {$urandom, $urandom, $urandom};
    b[1:0]   = 2'b01;
    b[25:2]  = lane_pat(l);
    b[33:26] = seg_par();
    b[57:34] = ~lane_pat(l);
    if (kind == 1) b[5] = ~b[5];
    if (kind == 2) b[33:26] = b[33:26] ^ 8'h10;
    return b;
  endfunction

  task automatic model(input logic [65:0] b, input bit v, input bit bl, input bit r);
    logic [1:0] ml;
    bit im, cons, good;
    e_bip = 1'b0;
    if (r) begin
      e_out = '0; e_ov = 1'b0; m_lock = 1'b0; m_cand = 1'b0;
      m_pos = 0; m_bad = 0; m_lane = 2'd0; m_cnt = 0;
      seg.delete();
      return;
    end
    e_out = b;
    e_ov  = v;
    if (!bl) begin
      m_lock = 1'b0; m_cand = 1'b0; m_bad = 0; m_pos = 0;
      seg.delete();
      return;
    end
    if (!v) return;
    im   = is_marker(b, ml);
    cons = 1'b0;
    if (!m_lock && !m_cand) begin
      if (im) begin
        m_lane = ml; m_pos = 0; m_cand = 1'b1; cons = 1'b1;
      end
    end else begin
      m_pos++;
      if (m_pos == AM) begin
        m_pos = 0;
        cons  = 1'b1;
        good  = im && (ml == m_lane);
        if (m_cand) begin
          m_cand = 1'b0; m_lock = good; m_bad = 0;
        end else if (good) begin
          m_bad = 0;
          if (b[33:26] !== seg_par()) begin
            e_bip = 1'b1;
            if (m_cnt < 65535) m_cnt++;
          end
        end else begin
          m_bad++;
          if (m_bad == LIM) begin
            m_lock = 1'b0; m_bad = 0;
          end
        end
      end
    end
    if (cons) begin
      seg.delete();
      e_ov = 1'b0;
    end
    seg.push_back(b);
  endtask

  task automatic cyc(input logic [65:0] b, input bit v, input bit bl, input bit r);
    block_in = b; block_valid = v; block_lock = bl; reset = r;
    @(posedge clk);
    model(b, v, bl, r);
    #1;
    check("block_out", block_out, e_out);
    check("out_valid", 66'(block_out_valid), 66'(e_ov));
    check("am_lock", 66'(am_lock), 66'(m_lock));
    check("lane_id", 66'(lane_id), 66'(m_lane));
    check("bip_error", 66'(bip_error), 66'(e_bip));
    check("bip_err_count", 66'(bip_err_count), 66'(m_cnt));
  endtask

  task automatic period(input logic [1:0] l, input int kind, input bit gaps);
    int n;
    bit v;
    n = 0;
    while (n < AM - 1) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      cyc(rnd_data(), v, 1'b1, 1'b0);
      if (v) n++;
    end
    if (gaps && $urandom_range(0, 1) == 1) cyc(rnd_data(), 1'b0, 1'b1, 1'b0);
    cyc(mk(l, kind), 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    bit v, bl, r;
    int d;
    logic [65:0] b;

    cyc(rnd_data(), 1'b1, 1'b1, 1'b1);
    cyc(rnd_data(), 1'b0, 1'b1, 1'b1);
    check("rst_am_lock", 66'(am_lock), 66'(0));
    check("rst_out", block_out, 66'(0));
    for (int i = 0; i < 5; i++) cyc(rnd_data(), 1'b1, 1'b1, 1'b0);

    // Lane 2 lock, then gapped valid during lock.
    cyc(mk(2'd2, 0), 1'b1, 1'b1, 1'b0);
    check("first_marker_removed", 66'(block_out_valid), 66'(0));
    period(2'd2, 0, 1'b0);
    check("lock_lane2", 66'(am_lock), 66'(1));
    check("lane_id2", 66'(lane_id), 66'(2));
    for (int i = 0; i < 3; i++) period(2'd2, 0, 1'b0);
    for (int i = 0; i < 3; i++) period(2'd2, 0, 1'b1);
    check("lock_held_gaps", 66'(am_lock), 66'(1));
    check("no_bip_errs", 66'(bip_err_count), 66'(0));

    // Relock on lane 0 and inject one BIP error.
    cyc(rnd_data(), 1'b1, 1'b0, 1'b0);
    cyc(mk(2'd0, 0), 1'b1, 1'b1, 1'b0);
    period(2'd0, 0, 1'b0);
    check("lock_lane0", 66'(am_lock), 66'(1));
    period(2'd0, 2, 1'b0);
    check("bip_pulse", 66'(bip_error), 66'(1));
    check("bip_count1", 66'(bip_err_count), 66'(1));

    // Four consecutive bad markers.
    for (int i = 0; i < 3; i++) begin
      period(2'd0, 1, 1'b0);
      check("lock_through_bad", 66'(am_lock), 66'(1));
    end
    period(2'd0, 1, 1'b0);
    check("lock_lost_4th", 66'(am_lock), 66'(0));

    // Lane 1 then lane 3: no lock.
    cyc(mk(2'd1, 0), 1'b1, 1'b1, 1'b0);
    period(2'd3, 0, 1'b0);
    check("lane_mismatch", 66'(am_lock), 66'(0));

    // block_lock glitch while locked, then relock.
    cyc(mk(2'd1, 0), 1'b1, 1'b1, 1'b0);
    period(2'd1, 0, 1'b0);
    period(2'd1, 0, 1'b0);
    check("lock_lane1", 66'(am_lock), 66'(1));
    cyc(rnd_data(), 1'b1, 1'b0, 1'b0);
    check("block_lock_drop", 66'(am_lock), 66'(0));
    cyc(mk(2'd1, 0), 1'b1, 1'b1, 1'b0);
    period(2'd1, 0, 1'b0);
    check("relock", 66'(am_lock), 66'(1));
    check("count_held", 66'(bip_err_count), 66'(1));

    // Reset mid-lock.
    cyc(rnd_data(), 1'b1, 1'b1, 1'b1);
    check("reset_drop", 66'(am_lock), 66'(0));
    check("reset_count", 66'(bip_err_count), 66'(0));

    // Random traffic with markers placed at model-predicted positions.
    for (int c = 0; c < 2000; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      bl = ($urandom_range(0, 99) != 0);
      r  = ($urandom_range(0, 399) == 0);
      d  = $urandom_range(0, 9);
      b  = rnd_data();
      if ((m_lock || m_cand) && m_pos == AM - 1) begin
        if (d < 6)       b = mk(m_lane, 0);
        else if (d == 6) b = mk(m_lane, 1);
        else if (d == 7) b = mk(m_lane, 2);
        else             b = mk(m_lane + 2'd1, 0);
      end else if (d == 0) begin
        b = mk(2'($urandom_range(0, 3)), 0);
      end
      cyc(b, v, bl, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
